// File: rtl/blackjack_pkg.sv
// rtl/blackjack_pkg.sv - shared card types, deck constants and index helpers
// Contents:
//   card_value_t / card_symbol_t : rank 1..13 and suit 0..3 encodings
//   DECK_SIZE / SUIT_SIZE        : deck geometry
//   SUIT_*                       : suit encodings shared with the game FSM
//   dealer_state_t               : dealer FSM states
//   idx_to_value / idx_to_symbol : deck index 0..51 -> (rank, suit)
package blackjack_pkg;

  typedef logic [3:0] card_value_t;
  typedef logic [1:0] card_symbol_t;

  localparam int DECK_SIZE = 52;
  localparam int SUIT_SIZE = 13;

  localparam card_symbol_t SUIT_CLUBS    = 2'd0;
  localparam card_symbol_t SUIT_DIAMONDS = 2'd1;
  localparam card_symbol_t SUIT_HEARTS   = 2'd2;
  localparam card_symbol_t SUIT_SPADES   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_DELIVER = 2'd2
  } dealer_state_t;

  // Suit is idx/13; done with compares to avoid a divider.
  function automatic card_symbol_t idx_to_symbol(logic [5:0] idx);
    if (idx >= 6'(3 * SUIT_SIZE)) return SUIT_SPADES;
    if (idx >= 6'(2 * SUIT_SIZE)) return SUIT_HEARTS;
    if (idx >= 6'(SUIT_SIZE))     return SUIT_DIAMONDS;
    return SUIT_CLUBS;
  endfunction

  // Rank is (idx mod 13) + 1, i.e. idx minus the suit base, plus one.
  function automatic card_value_t idx_to_value(logic [5:0] idx);
    logic [5:0] rem;
    rem = idx - 6'(SUIT_SIZE) * {4'b0000, idx_to_symbol(idx)};
    return 4'(rem + 6'd1);
  endfunction

endpackage

// File: rtl/card_dealer_if.sv
// rtl/card_dealer_if.sv - requester <-> dealer handshake bundle
// Signals:
//   shuffle, draw_req                 : requester -> dealer
//   draw_ack, draw_err                : dealer pulses
//   card_value, card_symbol           : last delivered card
//   cards_left, deck_empty            : deck status
// Modports: master (requester), slave (dealer)
interface card_dealer_if;
  import blackjack_pkg::*;

  logic         shuffle;
  logic         draw_req;
  logic         draw_ack;
  logic         draw_err;
  card_value_t  card_value;
  card_symbol_t card_symbol;
  logic [5:0]   cards_left;
  logic         deck_empty;

  modport master (
    output shuffle, draw_req,
    input  draw_ack, draw_err, card_value, card_symbol, cards_left, deck_empty
  );

  modport slave (
    input  shuffle, draw_req,
    output draw_ack, draw_err, card_value, card_symbol, cards_left, deck_empty
  );
endinterface

// File: rtl/card_dealer_lfsr16.sv
// rtl/card_dealer_lfsr16.sv - free-running 16-bit Fibonacci LFSR (taps 16,14,13,11)
// Ports:
//   clk     : posedge clock
//   rst     : asynchronous active-high reset, loads SEED
//   state_o : current LFSR state
// Parameter SEED must be nonzero or the register locks up at zero.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic        fb;

  // Taps 16,14,13,11 are bits 15,13,12,10 of a left-shifting register.
  assign fb = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEED;
    else     state_q <= {state_q[14:0], fb};
  end

  assign state_o = state_q;

endmodule

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - 52-card dealer drawing random unused cards from a used-mask
// Ports:
//   clk  : posedge clock
//   rst  : asynchronous active-high reset
//   bus  : card_dealer_if.slave (shuffle, draw_req in; draw_ack, draw_err,
//          card_value, card_symbol, cards_left, deck_empty out)
// Parameter LFSR_SEED: nonzero LFSR reset value.
// Macro CARD_DEALER_FIXED_ORDER_EN: when defined every search starts at index 0,
// so draws come out in ascending index order; the LFSR keeps running.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  card_dealer_if.slave  bus
);

  dealer_state_t          state_q, state_d;
  logic [DECK_SIZE-1:0]   mask_q, mask_d;
  logic [5:0]             cand_q, cand_d;
  logic [5:0]             left_q, left_d;
  card_value_t            value_q, value_d;
  card_symbol_t           symbol_q, symbol_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;

  logic [15:0] lfsr_state;
  logic [5:0]  start_idx;
  logic        unused_lfsr_bits;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .state_o (lfsr_state)
  );

`ifdef CARD_DEALER_FIXED_ORDER_EN
  assign start_idx        = 6'd0;
  assign unused_lfsr_bits = ^lfsr_state;
`else
  // Fold 52..63 back into range; slightly biased toward low indices, accepted.
  assign start_idx = (lfsr_state[5:0] >= 6'(DECK_SIZE))
                   ? lfsr_state[5:0] - 6'(DECK_SIZE)
                   : lfsr_state[5:0];
  assign unused_lfsr_bits = ^lfsr_state[15:6];
`endif

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cand_d   = cand_q;
    left_d   = left_q;
    value_d  = value_q;
    symbol_d = symbol_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;

    // Shuffle wins in every state: it refills the deck and aborts any draw.
    if (bus.shuffle) begin
      state_d  = ST_IDLE;
      mask_d   = '0;
      left_d   = 6'(DECK_SIZE);
      value_d  = '0;
      symbol_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.draw_req) begin
            if (left_q == 6'd0) begin
              err_d = 1'b1;
            end else begin
              cand_d  = start_idx;
              state_d = ST_SEARCH;
            end
          end
        end
        ST_SEARCH: begin
          // Linear probe with wrap; terminates because cards_left > 0.
          if (mask_q[cand_q]) begin
            cand_d = (cand_q == 6'(DECK_SIZE - 1)) ? 6'd0 : cand_q + 6'd1;
          end else begin
            mask_d[cand_q] = 1'b1;
            left_d         = left_q - 6'd1;
            value_d        = idx_to_value(cand_q);
            symbol_d       = idx_to_symbol(cand_q);
            state_d        = ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          ack_d   = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      cand_q   <= '0;
      left_q   <= 6'(DECK_SIZE);
      value_q  <= '0;
      symbol_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      cand_q   <= cand_d;
      left_q   <= left_d;
      value_q  <= value_d;
      symbol_q <= symbol_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign bus.draw_ack    = ack_q;
  assign bus.draw_err    = err_q;
  assign bus.card_value  = value_q;
  assign bus.card_symbol = symbol_q;
  assign bus.cards_left  = left_q;
  assign bus.deck_empty  = (left_q == 6'd0);

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - scoreboard bench for card_dealer (random or fixed-order build)
// Ports: none; drives the dealer through a card_dealer_if instance.
`timescale 1ns/1ps
module tb_card_dealer;
  import blackjack_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  card_dealer_if bus();

  card_dealer #(.LFSR_SEED(16'hACE1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] val;
    logic [1:0] sym;
    logic [5:0] left;
    int         ack_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          err_exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc;
  logic [51:0] model_mask;
  int          model_left;
  logic [51:0] seen;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [15:0] lfsr_at(int n);
    logic [15:0] s;
    s = 16'hACE1;
    for (int k = 0; k < n; k++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    return s;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the dealer pulses ack or err.
  always @(negedge clk) begin
    exp_t e;
    int   ec;
    if (!rst) begin
      if (bus.draw_ack && bus.draw_err) check("ack_err_exclusive", 1, 0);
      if (bus.draw_ack) begin
        if (exp_q.size() == 0) check("unexpected_ack", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("card_value", bus.card_value, e.val);
          check("card_symbol", bus.card_symbol, e.sym);
          check("cards_left", bus.cards_left, e.left);
          check("ack_cycle", cyc, e.ack_cyc);
        end
      end
      if (bus.draw_err) begin
        if (err_exp_q.size() == 0) check("unexpected_err", 1, 0);
        else begin
          ec = err_exp_q.pop_front();
          check("err_cycle", cyc, ec);
        end
      end
    end
  end

  // Called at a negedge with the dealer idle; next posedge accepts the request.
  task automatic draw(input bit expect_err, output logic [3:0] v, output logic [1:0] s);
    int          start, p, ci;
    logic [15:0] l;
    logic [5:0]  cand;
    exp_t        e;
    bit          got;
    start = cyc;
    if (expect_err) begin
      err_exp_q.push_back(start + 1);
    end else begin
`ifdef CARD_DEALER_FIXED_ORDER_EN
      l    = lfsr_at(start);
      cand = 6'd0;
`else
      l    = lfsr_at(start);
      cand = l[5:0];
      if (cand >= 6'd52) cand = cand - 6'd52;
`endif
      p = 0;
      while (model_mask[cand]) begin
        p++;
        cand = (cand == 6'd51) ? 6'd0 : cand + 6'd1;
      end
      model_mask[cand] = 1'b1;
      model_left--;
      ci        = int'(cand);
      e.val     = 4'(ci % 13 + 1);
      e.sym     = 2'(ci / 13);
      e.left    = 6'(model_left);
      e.ack_cyc = start + 3 + p;
      exp_q.push_back(e);
    end
    bus.draw_req = 1'b1;
    got = 0;
    for (int k = 0; k < 80 && !got; k++) begin
      @(negedge clk);
      if (bus.draw_ack || bus.draw_err) got = 1;
    end
    bus.draw_req = 1'b0;
    if (!got) check("draw_timeout", 0, 1);
    v = bus.card_value;
    s = bus.card_symbol;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_cards_left"}, bus.cards_left, 52);
    check({tag, "_deck_empty"}, bus.deck_empty, 0);
    check({tag, "_card_value"}, bus.card_value, 0);
    check({tag, "_card_symbol"}, bus.card_symbol, 0);
    check({tag, "_draw_ack"}, bus.draw_ack, 0);
    check({tag, "_draw_err"}, bus.draw_err, 0);
  endtask

  initial begin
    logic [3:0] v;
    logic [1:0] s;
    int         idx;
    bus.shuffle  = 1'b0;
    bus.draw_req = 1'b0;
    model_mask   = '0;
    model_left   = 52;
    seen         = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Deal the whole deck; first card and 14th card have hand-computed values.
    for (int i = 1; i <= 52; i++) begin
      draw(0, v, s);
      idx = int'(s) * 13 + int'(v) - 1;
      if (v >= 4'd1 && v <= 4'd13) begin
        check("distinct_card", seen[idx], 0);
        seen[idx] = 1'b1;
      end else begin
        check("card_value_range", v, 1);
      end
`ifdef CARD_DEALER_FIXED_ORDER_EN
      if (i == 1)  begin check("first_value", v, 1); check("first_symbol", s, 0); end
      if (i == 14) begin check("draw14_value", v, 1); check("draw14_symbol", s, 1); end
`else
      // Seed 0xACE1 -> low bits 33 -> index 33 -> eight of suit 2.
      if (i == 1)  begin check("first_value", v, 8); check("first_symbol", s, 2); end
`endif
      @(negedge clk);
    end
    check("all_seen", ($countones(seen) == 52) ? 1 : 0, 1);
    check("empty_cards_left", bus.cards_left, 0);
    check("empty_deck_empty", bus.deck_empty, 1);

    // 53rd request is refused.
    draw(1, v, s);
    repeat (3) @(negedge clk);
    check("err_no_ack_left", bus.cards_left, 0);

    // Shuffle refills the deck on the next cycle.
    bus.shuffle = 1'b1;
    @(negedge clk);
    bus.shuffle = 1'b0;
    model_mask = '0; model_left = 52; seen = '0;
    check("shuffle_cards_left", bus.cards_left, 52);
    check("shuffle_deck_empty", bus.deck_empty, 0);
    check("shuffle_card_value", bus.card_value, 0);
    draw(0, v, s);
    @(negedge clk);

    // Shuffle one cycle after acceptance aborts the draw.
    bus.draw_req = 1'b1;
    @(negedge clk);
    bus.draw_req = 1'b0;
    bus.shuffle  = 1'b1;
    @(negedge clk);
    bus.shuffle  = 1'b0;
    model_mask = '0; model_left = 52;
    check("abort_cards_left", bus.cards_left, 52);
    check("abort_card_value", bus.card_value, 0);
    check("abort_card_symbol", bus.card_symbol, 0);
    check("abort_draw_ack", bus.draw_ack, 0);
    repeat (6) @(negedge clk);
    draw(0, v, s);
    @(negedge clk);

    // Asynchronous reset in the middle of a search.
    bus.draw_req = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    bus.draw_req = 1'b0;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    model_mask = '0; model_left = 52;
    repeat (6) @(negedge clk);
    draw(0, v, s);
    repeat (3) @(negedge clk);

    check("scoreboard_drained", exp_q.size() + err_exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 Parameter: LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
REQ-002 Ports:
- clk  in  1  posedge clock
- rst  in  1  asynchronous, active-high reset
- shuffle  in  1  single-cycle request to return all 52 cards to the deck
- draw_req  in  1  level request for one card
- draw_ack  out  1  single-cycle pulse: card_value and card_symbol hold a new card
- draw_err  out  1  single-cycle pulse: draw refused, deck empty
- card_value  out  4  rank 1..13 (1=ace, 11..13=J/Q/K)
- card_symbol  out  2  suit 0..3
- cards_left  out  6  cards remaining, 0..52
- deck_empty  out  1  high when cards_left==0

Function
REQ-003 The block shall hold a 52-bit used-mask; card index i maps to card_value=(i mod 13)+1 and card_symbol=i/13.
REQ-004 A 16-bit Fibonacci LFSR, taps 16,14,13,11, shall advance every clk cycle regardless of state.
REQ-005 States shall be IDLE, SEARCH and DELIVER; reset state is IDLE.
REQ-006 IDLE: shuffle=1 -> clear mask and set cards_left=52 next cycle; draw_req ignored that cycle (shuffle wins).
REQ-007 IDLE: draw_req=1, shuffle=0, deck_empty=1 -> draw_err=1 for exactly one cycle, remain in IDLE.
REQ-008 IDLE: draw_req=1, shuffle=0, deck_empty=0 -> load candidate index = lfsr[5:0], minus 52 if >=52; go to SEARCH.
REQ-009 SEARCH: candidate used -> candidate = (candidate==51) ? 0 : candidate+1, stay; candidate free -> set its mask bit, decrement cards_left, register card_value/card_symbol, go to DELIVER.
REQ-010 DELIVER: draw_ack=1 for one cycle, then IDLE; ack occurs 3+p cycles after the accepting edge, p = used slots probed (0..51).
REQ-011 card_value/card_symbol shall stay stable from ack until the next ack, shuffle or reset, so a frame-rate consumer can sample them late.
REQ-012 The requester shall drop draw_req in the cycle it sees draw_ack; a request still high in IDLE starts a new draw.
REQ-013 shuffle in SEARCH or DELIVER shall abort the draw: no ack, mask cleared, cards_left=52, card outputs zeroed, IDLE next cycle.
REQ-014 A card shall never be delivered twice between shuffles; the 52 draws after a shuffle shall yield all 52 distinct cards.
REQ-015 draw_ack and draw_err shall never be high in the same cycle.

Reset
REQ-016 While rst=1, regardless of clk: state=IDLE, mask all zero, cards_left=52, deck_empty=0, card_value=0, card_symbol=0, draw_ack=0, draw_err=0, LFSR=LFSR_SEED.
REQ-017 rst during SEARCH/DELIVER shall cancel the draw with no ack pulse after release.

Configuration
REQ-018 Macro CARD_DEALER_FIXED_ORDER_EN defined: candidate index in REQ-008 shall be forced to 0, giving deterministic ascending draws (index 0,1,2,...); LFSR still runs.
REQ-019 Macro undefined: candidate from LFSR as in REQ-008.

Structure
REQ-020 blackjack_pkg shall hold card_value_t (4 bit), card_symbol_t (2 bit), DECK_SIZE=52, SUIT_SIZE=13 and suit encoding constants, shared with the game FSM.
REQ-021 The LFSR shall be a separate sub-module, lfsr16, with ports clk, rst, seed parameter and 16-bit state output.

Verification
REQ-022 FIXED_ORDER, rst then one draw -> ack 3 cycles after acceptance, card_value=1, card_symbol=0, cards_left=51.
REQ-023 FIXED_ORDER, 14 draws -> 14th returns card_value=1, card_symbol=1 (index 13).
REQ-024 Random mode, 52 draws -> 52 distinct (value,symbol) pairs, cards_left=0, deck_empty=1; 53rd draw_req -> draw_err pulse, no ack.
REQ-025 Empty deck, shuffle pulse -> next cycle cards_left=52, deck_empty=0; next draw acks normally.
REQ-026 shuffle pulse one cycle after draw accepted -> no draw_ack, cards_left=52, card_value=0, IDLE.
REQ-027 rst asserted mid-SEARCH between clock edges -> outputs take reset values immediately; no ack after release.
